// File: rtl/sdram_responder_if.sv
// sdram_responder_if: SDRAM pin bundle between host controller and device.
// The host drives command/address/mask/write data; the device drives read data.
interface sdram_responder_if;
    logic [12:0] SDRAM_A;
    logic [1:0]  SDRAM_BA;
    logic        SDRAM_nCS;
    logic        SDRAM_nRAS;
    logic        SDRAM_nCAS;
    logic        SDRAM_nWE;
    logic        SDRAM_CKE;
    logic        SDRAM_DQML;
    logic        SDRAM_DQMH;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic [1:0]  dq_oe;

    modport master (
        output SDRAM_A, SDRAM_BA, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
        output SDRAM_CKE, SDRAM_DQML, SDRAM_DQMH, dq_in,
        input  dq_out, dq_oe
    );

    modport slave (
        input  SDRAM_A, SDRAM_BA, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
        input  SDRAM_CKE, SDRAM_DQML, SDRAM_DQMH, dq_in,
        output dq_out, dq_oe
    );
endinterface

// File: rtl/sdram_responder.sv
// sdram_responder: chip-side SDRAM model. Decodes host commands, serves
// reads and writes from a small internal RAM, and latches protocol
// violations in sticky error bits.
module sdram_responder #(
    parameter int ROW_BITS    = 4,
    parameter int COL_BITS    = 4,
    parameter int TRCD        = 2,
    parameter int TRFC        = 7,
    parameter int REFRESH_MAX = 1600
) (
    input  logic             clk,
    input  logic             init_n,
    sdram_responder_if.slave bus,
    output logic [12:0]      mode_reg,
    output logic [7:0]       err
);
    localparam int AW = 2 + ROW_BITS + COL_BITS;
    localparam int TW = $clog2(TRCD + 1);
    localparam int FW = $clog2(TRFC + 1);
    localparam int RW = $clog2(REFRESH_MAX + 2);

    typedef enum logic [2:0] {
        CMD_NOP, CMD_ACTIVE, CMD_READ, CMD_WRITE, CMD_PRECHARGE, CMD_REFRESH, CMD_LOAD_MODE
    } cmd_e;

    typedef enum logic {BANK_IDLE, BANK_ACTIVE} bank_state_e;

    cmd_e                cmd;
    bank_state_e         state_q [4], state_d [4];
    logic [ROW_BITS-1:0] row_q   [4], row_d   [4];
    logic [TW-1:0]       trcd_q  [4], trcd_d  [4];
    logic [12:0]         mode_reg_q, mode_reg_d;
    logic                mode_valid_q, mode_valid_d;
    logic [7:0]          err_q, err_d;
    logic [FW-1:0]       trfc_q, trfc_d;
    logic [RW-1:0]       ref_q, ref_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_cl3_q, rd_cl3_d;
    logic [1:0]          rd_oe_q, rd_oe_d;
    logic                hold_valid_q, hold_valid_d;
    logic [1:0]          hold_oe_q, hold_oe_d;
    logic [15:0]         hold_data_q, hold_data_d;
    logic [15:0]         dq_out_q, dq_out_d;
    logic [1:0]          dq_oe_q, dq_oe_d;
    logic [15:0]         mem [2**AW];
    logic [15:0]         rd_data_q;
    logic [AW-1:0]       addr;
    logic                wr_en, rd_en, any_open, cl3;
    logic [1:0]          ba;

    assign ba   = bus.SDRAM_BA;
    assign addr = {ba, row_q[ba], bus.SDRAM_A[COL_BITS-1:0]};
    // Any CAS latency other than 3 (including illegal ones) runs as CL=2.
    assign cl3  = (mode_reg_q[6:4] == 3'd3);

    // Command decode; CKE low, chip deselect and BURST_TERMINATE all behave as NOP.
    always_comb begin
        cmd = CMD_NOP;
        if (bus.SDRAM_CKE && !bus.SDRAM_nCS) begin
            case ({bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE})
                3'b011:  cmd = CMD_ACTIVE;
                3'b101:  cmd = CMD_READ;
                3'b100:  cmd = CMD_WRITE;
                3'b010:  cmd = CMD_PRECHARGE;
                3'b001:  cmd = CMD_REFRESH;
                3'b000:  cmd = CMD_LOAD_MODE;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    // Bank FSMs, timers, mode register, error flags and read pipeline next state.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d      = state_q;
        row_d        = row_q;
        for (int b = 0; b < 4; b++) begin
            trcd_d[b] = (trcd_q[b] != '0) ? trcd_q[b] - TW'(1) : '0;
        end
        mode_reg_d   = mode_reg_q;
        mode_valid_d = mode_valid_q;
        err_d        = err_q;
        trfc_d       = (trfc_q != '0) ? trfc_q - FW'(1) : '0;
        ref_d        = ref_q;
        if (mode_valid_q && ref_q <= RW'(REFRESH_MAX)) ref_d = ref_q + RW'(1);
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        any_open     = 1'b0;
        for (int b = 0; b < 4; b++) any_open |= (state_q[b] == BANK_ACTIVE);

        if (cmd != CMD_NOP && trfc_q != '0) err_d[3] = 1'b1;

        case (cmd)
            CMD_ACTIVE: begin
                if (state_q[ba] == BANK_ACTIVE) err_d[2] = 1'b1;
                state_d[ba] = BANK_ACTIVE;
                row_d[ba]   = bus.SDRAM_A[ROW_BITS-1:0];
                trcd_d[ba]  = TW'(TRCD - 1);
            end
            CMD_PRECHARGE: begin
                if (bus.SDRAM_A[10]) begin
                    for (int b = 0; b < 4; b++) state_d[b] = BANK_IDLE;
                end else begin
                    state_d[ba] = BANK_IDLE;
                end
            end
            CMD_REFRESH: begin
                if (any_open) err_d[3] = 1'b1;
                trfc_d = FW'(TRFC - 1);
                ref_d  = '0;
            end
            CMD_LOAD_MODE: begin
                if (any_open) err_d[6] = 1'b1;
                if (!(bus.SDRAM_A[6:4] inside {3'd2, 3'd3}) || bus.SDRAM_A[2:0] != 3'b000)
                    err_d[5] = 1'b1;
                mode_reg_d   = bus.SDRAM_A;
                mode_valid_d = 1'b1;
            end
            CMD_READ, CMD_WRITE: begin
                if (!mode_valid_q) err_d[7] = 1'b1;
                if (state_q[ba] == BANK_IDLE) begin
                    err_d[0] = 1'b1;
                end else begin
                    if (trcd_q[ba] != '0) err_d[1] = 1'b1;
                    wr_en = (cmd == CMD_WRITE);
                    rd_en = (cmd == CMD_READ);
                    if (bus.SDRAM_A[10]) state_d[ba] = BANK_IDLE;
                end
            end
            default: ;
        endcase

        if (ref_d > RW'(REFRESH_MAX)) err_d[4] = 1'b1;

        // Stage 1: RAM read issued this edge. Stage 2: extra delay for CL=3.
        // Stage 3: output register, loaded the edge before the host samples.
        rd_valid_d   = rd_en;
        rd_cl3_d     = cl3;
        rd_oe_d      = ~{bus.SDRAM_DQMH, bus.SDRAM_DQML};
        hold_valid_d = rd_valid_q && rd_cl3_q;
        hold_oe_d    = rd_oe_q;
        hold_data_d  = rd_data_q;
        dq_out_d     = dq_out_q;
        dq_oe_d      = 2'b00;
        if (hold_valid_q) begin
            dq_out_d = hold_data_q;
            dq_oe_d  = hold_oe_q;
        end else if (rd_valid_q && !rd_cl3_q) begin
            dq_out_d = rd_data_q;
            dq_oe_d  = rd_oe_q;
        end
    end

    // Storage array with per-byte write and registered read.
    // NOTE: the RAM has no reset so it maps onto block RAM; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (wr_en && !bus.SDRAM_DQML) mem[addr][7:0]  <= bus.dq_in[7:0];
        if (wr_en && !bus.SDRAM_DQMH) mem[addr][15:8] <= bus.dq_in[15:8];
        if (rd_en) rd_data_q <= mem[addr];
    end

    // Control state register; reset drops dq_oe immediately and discards pending reads.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            for (int b = 0; b < 4; b++) begin
                state_q[b] <= BANK_IDLE;
                row_q[b]   <= '0;
                trcd_q[b]  <= '0;
            end
            mode_reg_q   <= '0;
            mode_valid_q <= 1'b0;
            err_q        <= '0;
            trfc_q       <= '0;
            ref_q        <= '0;
            rd_valid_q   <= 1'b0;
            rd_cl3_q     <= 1'b0;
            rd_oe_q      <= 2'b00;
            hold_valid_q <= 1'b0;
            hold_oe_q    <= 2'b00;
            hold_data_q  <= '0;
            dq_out_q     <= '0;
            dq_oe_q      <= 2'b00;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            trcd_q       <= trcd_d;
            mode_reg_q   <= mode_reg_d;
            mode_valid_q <= mode_valid_d;
            err_q        <= err_d;
            trfc_q       <= trfc_d;
            ref_q        <= ref_d;
            rd_valid_q   <= rd_valid_d;
            rd_cl3_q     <= rd_cl3_d;
            rd_oe_q      <= rd_oe_d;
            hold_valid_q <= hold_valid_d;
            hold_oe_q    <= hold_oe_d;
            hold_data_q  <= hold_data_d;
            dq_out_q     <= dq_out_d;
            dq_oe_q      <= dq_oe_d;
        end
    end

    assign bus.dq_out = dq_out_q;
    assign bus.dq_oe  = dq_oe_q;
    assign mode_reg   = mode_reg_q;
    assign err        = err_q;
endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: scenario tasks drive SDRAM commands; expected read data
// is queued when a READ is issued and compared when the device drives dq_oe.
module tb_sdram_responder;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;

    typedef struct {
        int          due;
        logic [15:0] data;
        logic [1:0]  oe;
    } exp_t;

    logic        clk;
    logic        init_n;
    logic [12:0] mode_reg;
    logic [7:0]  err;
    int          checks;
    int          failures;
    int          cyc;
    int          last_edge;
    int          cur_cl;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] mon_mask;

    sdram_responder_if bus ();

    sdram_responder dut (
        .clk      (clk),
        .init_n   (init_n),
        .bus      (bus),
        .mode_reg (mode_reg),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every cycle with dq_oe active must match the oldest pending read.
    always @(negedge clk) begin
        if (init_n && bus.dq_oe !== 2'b00) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_oe: got oe=%b dq_out=%h at edge %0d, required no output", bus.dq_oe, bus.dq_out, cyc + 1);
            end else begin
                mon_e = sb.pop_front();
                mon_mask = {{8{mon_e.oe[1]}}, {8{mon_e.oe[0]}}};
                if (bus.dq_oe !== mon_e.oe || (bus.dq_out & mon_mask) !== (mon_e.data & mon_mask) || cyc + 1 != mon_e.due) begin
                    failures++;
                    $display("FAIL read_data: got oe=%b data=%h edge=%0d, required oe=%b data=%h edge=%0d",
                             bus.dq_oe, bus.dq_out, cyc + 1, mon_e.oe, mon_e.data, mon_e.due);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive_idle();
        {bus.SDRAM_nCS, bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = C_NOP;
        bus.SDRAM_BA   = 2'd0;
        bus.SDRAM_A    = 13'd0;
        bus.SDRAM_DQML = 1'b0;
        bus.SDRAM_DQMH = 1'b0;
        bus.dq_in      = 16'h0000;
    endtask

    // One command sampled at the next rising edge; last_edge records that edge.
    task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic dqmh, input logic dqml, input logic [15:0] d);
        @(negedge clk);
        last_edge = cyc + 1;
        {bus.SDRAM_nCS, bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = c;
        bus.SDRAM_BA   = ba;
        bus.SDRAM_A    = a;
        bus.SDRAM_DQMH = dqmh;
        bus.SDRAM_DQML = dqml;
        bus.dq_in      = d;
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic nop(input int n);
        repeat (n) issue(C_NOP, 2'd0, 13'd0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic activate(input logic [1:0] ba, input logic [12:0] row);
        issue(C_ACT, ba, row, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic write_word(input logic [1:0] ba, input logic [3:0] col, input logic [15:0] d,
                              input logic dqmh, input logic dqml, input logic ap);
        issue(C_WR, ba, {2'b00, ap, 6'd0, col}, dqmh, dqml, d);
    endtask

    task automatic read_word(input logic [1:0] ba, input logic [3:0] col, input logic dqmh,
                             input logic dqml, input logic [15:0] exp_data, input logic expect_data);
        exp_t e;
        issue(C_RD, ba, {9'd0, col}, dqmh, dqml, 16'h0);
        if (expect_data) begin
            e.due  = last_edge + cur_cl;
            e.data = exp_data;
            e.oe   = ~{dqmh, dqml};
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        drive_idle();
        bus.SDRAM_CKE = 1'b1;
        init_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        init_n = 1'b1;
    endtask

    task automatic init_seq(input logic [12:0] mode);
        issue(C_PRE, 2'd0, 13'h400, 1'b0, 1'b0, 16'h0);
        issue(C_REF, 2'd0, 13'h000, 1'b0, 1'b0, 16'h0);
        nop(7);
        issue(C_REF, 2'd0, 13'h000, 1'b0, 1'b0, 16'h0);
        nop(7);
        issue(C_LMR, 2'd0, mode, 1'b0, 1'b0, 16'h0);
        cur_cl = (mode[6:4] == 3'd3) ? 3 : 2;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d reads still pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        init_n = 1'b0;
        drive_idle();
        bus.SDRAM_CKE = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.dq_oe !== 2'b00 || bus.dq_out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_dq: got oe=%b out=%h, required oe=00 out=0000", bus.dq_oe, bus.dq_out);
        end
        checks++;
        if (mode_reg !== 13'h0 || err !== 8'h00) begin
            failures++;
            $display("FAIL reset_regs: got mode=%h err=%h, required mode=0000 err=00", mode_reg, err);
        end
        @(negedge clk);
        init_n = 1'b1;
    endtask

    task automatic test_init();
        do_reset();
        init_seq(13'h220);
        checks++;
        if (mode_reg !== 13'h220) begin
            failures++;
            $display("FAIL init_mode: got %h, required 0220", mode_reg);
        end
        checks++;
        if (err !== 8'h00) begin
            failures++;
            $display("FAIL init_err: got %h, required 00", err);
        end
    endtask

    task automatic test_cl2();
        do_reset();
        init_seq(13'h220);
        activate(2'd1, 13'h003);
        nop(2);
        write_word(2'd1, 4'd5, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        read_word(2'd1, 4'd5, 1'b0, 1'b0, 16'hBEEF, 1'b1);
        drain("cl2");
        checks++;
        if (err !== 8'h00) begin
            failures++;
            $display("FAIL cl2_err: got %h, required 00", err);
        end
    endtask

    task automatic test_back_to_back_cl3();
        do_reset();
        init_seq(13'h230);
        activate(2'd1, 13'h003);
        nop(2);
        write_word(2'd1, 4'd5, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        write_word(2'd1, 4'd6, 16'hCAFE, 1'b0, 1'b0, 1'b0);
        read_word(2'd1, 4'd5, 1'b0, 1'b0, 16'hBEEF, 1'b1);
        read_word(2'd1, 4'd6, 1'b0, 1'b0, 16'hCAFE, 1'b1);
        read_word(2'd1, 4'd5, 1'b0, 1'b0, 16'hBEEF, 1'b1);
        drain("cl3");
        checks++;
        if (err !== 8'h00) begin
            failures++;
            $display("FAIL cl3_err: got %h, required 00", err);
        end
    endtask

    task automatic test_byte_mask();
        do_reset();
        init_seq(13'h220);
        activate(2'd0, 13'h00A);
        nop(2);
        write_word(2'd0, 4'd7, 16'h1234, 1'b0, 1'b0, 1'b0);
        write_word(2'd0, 4'd7, 16'hABCD, 1'b1, 1'b0, 1'b0);
        read_word(2'd0, 4'd7, 1'b0, 1'b0, 16'h12CD, 1'b1);
        read_word(2'd0, 4'd7, 1'b0, 1'b1, 16'h12CD, 1'b1);
        drain("mask");
    endtask

    task automatic test_idle_read();
        do_reset();
        init_seq(13'h220);
        read_word(2'd2, 4'd0, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.dq_oe !== 2'b00) begin
                failures++;
                $display("FAIL idle_oe: got %b, required 00", bus.dq_oe);
            end
        end
        checks++;
        if (err !== 8'h01) begin
            failures++;
            $display("FAIL idle_err: got %h, required 01", err);
        end
    endtask

    task automatic test_trcd();
        do_reset();
        init_seq(13'h220);
        activate(2'd0, 13'h001);
        nop(2);
        write_word(2'd0, 4'd2, 16'h5A5A, 1'b0, 1'b0, 1'b0);
        issue(C_PRE, 2'd0, 13'h000, 1'b0, 1'b0, 16'h0);
        activate(2'd0, 13'h001);
        read_word(2'd0, 4'd2, 1'b0, 1'b0, 16'h5A5A, 1'b1);
        drain("trcd");
        checks++;
        if (err !== 8'h02) begin
            failures++;
            $display("FAIL trcd_err: got %h, required 02", err);
        end
    endtask

    task automatic test_trfc();
        do_reset();
        init_seq(13'h220);
        issue(C_REF, 2'd0, 13'h000, 1'b0, 1'b0, 16'h0);
        nop(1);
        checks++;
        if (err !== 8'h00) begin
            failures++;
            $display("FAIL trfc_pre_err: got %h, required 00", err);
        end
        activate(2'd0, 13'h000);
        checks++;
        if (err !== 8'h08) begin
            failures++;
            $display("FAIL trfc_err: got %h, required 08", err);
        end
    endtask

    task automatic test_load_mode_errors();
        do_reset();
        init_seq(13'h220);
        activate(2'd0, 13'h000);
        nop(2);
        issue(C_LMR, 2'd0, 13'h250, 1'b0, 1'b0, 16'h0);
        cur_cl = 2;
        checks++;
        if (err !== 8'h60 || mode_reg !== 13'h250) begin
            failures++;
            $display("FAIL lmr_err: got err=%h mode=%h, required err=60 mode=0250", err, mode_reg);
        end
        issue(C_PRE, 2'd0, 13'h400, 1'b0, 1'b0, 16'h0);
        activate(2'd3, 13'h000);
        nop(2);
        write_word(2'd3, 4'd1, 16'h0F0F, 1'b0, 1'b0, 1'b0);
        read_word(2'd3, 4'd1, 1'b0, 1'b0, 16'h0F0F, 1'b1);
        drain("cl_fallback");
        checks++;
        if (err !== 8'h60) begin
            failures++;
            $display("FAIL lmr_final_err: got %h, required 60", err);
        end
    endtask

    task automatic test_refresh_timeout();
        do_reset();
        init_seq(13'h220);
        nop(1000);
        issue(C_REF, 2'd0, 13'h000, 1'b0, 1'b0, 16'h0);
        nop(1600);
        checks++;
        if (err !== 8'h00) begin
            failures++;
            $display("FAIL refresh_1600_err: got %h, required 00", err);
        end
        nop(1);
        checks++;
        if (err !== 8'h10) begin
            failures++;
            $display("FAIL refresh_1601_err: got %h, required 10", err);
        end
    endtask

    task automatic test_auto_precharge();
        do_reset();
        init_seq(13'h220);
        activate(2'd1, 13'h003);
        nop(2);
        write_word(2'd1, 4'd5, 16'h1111, 1'b0, 1'b0, 1'b1);
        read_word(2'd1, 4'd5, 1'b0, 1'b0, 16'h0, 1'b0);
        nop(3);
        checks++;
        if (err !== 8'h01) begin
            failures++;
            $display("FAIL autopre_err: got %h, required 01", err);
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        init_seq(13'h220);
        read_word(2'd2, 4'd0, 1'b0, 1'b0, 16'h0, 1'b0);
        activate(2'd1, 13'h003);
        nop(2);
        write_word(2'd1, 4'd5, 16'h7777, 1'b0, 1'b0, 1'b0);
        read_word(2'd1, 4'd5, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        init_n = 1'b0;
        #1;
        checks++;
        if (bus.dq_oe !== 2'b00 || err !== 8'h00) begin
            failures++;
            $display("FAIL midread_reset: got oe=%b err=%h, required oe=00 err=00", bus.dq_oe, err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        init_n = 1'b1;
        nop(4);
        checks++;
        if (bus.dq_oe !== 2'b00 || err !== 8'h00) begin
            failures++;
            $display("FAIL midread_after: got oe=%b err=%h, required oe=00 err=00", bus.dq_oe, err);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        last_edge = 0;
        cur_cl    = 2;
        init_n    = 1'b0;
        bus.SDRAM_CKE = 1'b1;
        drive_idle();

        test_reset();
        test_init();
        test_cl2();
        test_back_to_back_cl3();
        test_byte_mask();
        test_idle_read();
        test_trcd();
        test_trfc();
        test_load_mode_errors();
        test_auto_precharge();
        test_reset_mid_read();
        test_refresh_timeout();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
